// File: rtl/keypad_scan_ctrl.sv
// 3x4 keypad scanner: drives one column low at a time, debounces whole frames and
// encodes a single keypress into an Avalon-MM status register with a level interrupt.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows_in,
  output logic [2:0]  cols_out,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DRIVE, EVAL} state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    rows_meta_q, rows_meta_d, rows_sync_q, rows_sync_d;
  logic [11:0]   frame_q, frame_d, prev_frame_q, prev_frame_d, snap_q, snap_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d, overrun_q, overrun_d, pressed_q, pressed_d;
  logic          enable_q, enable_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic [2:0]    cols_q, cols_d;

  logic          rd_status, wr_ctrl, new_key, frame_same, accept;
  logic [3:0]    key_idx;
  logic          unused_wdata;

  assign unused_wdata = ^writedata[31:2];

  always_comb begin
    rd_status    = chipselect & read & (address == 2'd0);
    wr_ctrl      = chipselect & ~write_n & (address == 2'd1);
    state_d      = state_q;
    col_d        = col_q;
    cnt_d        = cnt_q;
    rows_meta_d  = rows_in;
    rows_sync_d  = rows_meta_q;
    frame_d      = frame_q;
    prev_frame_d = prev_frame_q;
    snap_d       = snap_q;
    stable_d     = stable_q;
    code_d       = code_q;
    pressed_d    = pressed_q;
    cols_d       = cols_q;
    enable_d     = enable_q;
    irq_en_d     = irq_en_q;
    new_key      = 1'b0;
    frame_same   = (frame_q == prev_frame_q);
    accept       = 1'b0;
    key_idx      = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (frame_q[i]) key_idx = 4'(i);
    end

    if (wr_ctrl) begin
      enable_d = writedata[0];
      irq_en_d = writedata[1];
    end

    // Disabling abandons the partial frame but keeps the reported key
    if (!enable_q) begin
      state_d  = IDLE;
      col_d    = 2'd0;
      cnt_d    = '0;
      cols_d   = 3'b111;
      stable_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DRIVE;
          col_d   = 2'd0;
          cnt_d   = '0;
          cols_d  = 3'b110;
        end
        DRIVE: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            for (int r = 0; r < 4; r++) frame_d[r*3 + int'(col_q)] = ~rows_sync_q[r];
            if (col_q == 2'd2) begin
              state_d = EVAL;
              cols_d  = 3'b111;
            end else begin
              col_d  = col_q + 2'd1;
              cols_d = ~(3'b001 << (col_q + 2'd1));
            end
          end
        end
        EVAL: begin
          state_d      = DRIVE;
          col_d        = 2'd0;
          cnt_d        = '0;
          cols_d       = 3'b110;
          prev_frame_d = frame_q;
          if (!frame_same)                stable_d = SW'(1);
          else if (stable_q != STABLE_MAX) stable_d = stable_q + 1'b1;
          // A changed frame with a one-scan window counts as a fresh arrival
          accept = (stable_d == STABLE_MAX) && (!frame_same || stable_q != STABLE_MAX);
          if (accept) begin
            snap_d = frame_q;
            if ($countones(frame_q) == 1 && !pressed_q) begin
              new_key   = 1'b1;
              code_d    = key_idx;
              pressed_d = 1'b1;
            end else if (frame_q == 12'd0) begin
              pressed_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    valid_d   = new_key | (valid_q & ~rd_status);
    overrun_d = rd_status ? 1'b0 : (overrun_q | (new_key & valid_q));
    irq_d     = valid_d & irq_en_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= 2'd0;
      cnt_q        <= '0;
      rows_meta_q  <= 4'b1111;
      rows_sync_q  <= 4'b1111;
      frame_q      <= '0;
      prev_frame_q <= '0;
      snap_q       <= '0;
      stable_q     <= '0;
      code_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      pressed_q    <= 1'b0;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      cols_q       <= 3'b111;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      rows_meta_q  <= rows_meta_d;
      rows_sync_q  <= rows_sync_d;
      frame_q      <= frame_d;
      prev_frame_q <= prev_frame_d;
      snap_q       <= snap_d;
      stable_q     <= stable_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      pressed_q    <= pressed_d;
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      cols_q       <= cols_d;
    end
  end

  assign cols_out = cols_q;
  assign irq      = irq_q;

  always_comb begin
    case (address)
      2'd0:    readdata = {21'd0, pressed_q, overrun_q, valid_q, 4'd0, code_q};
      2'd1:    readdata = {30'd0, irq_en_q, enable_q};
      2'd2:    readdata = {20'd0, snap_q};
      default: readdata = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad pin model plus a phase-counting reference model
// of scan, frame debounce and the register map, driven by directed and random steps.
module tb_keypad_scan_ctrl;
  localparam int S  = 4;
  localparam int DB = 2;
  localparam int FR = 3*S + 1;

  logic        clk = 1'b0, reset = 1'b1;
  logic [3:0]  rows_in;
  logic [2:0]  cols_out;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0, read = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = 32'd0, readdata;
  logic        irq;
  logic [11:0] keys = 12'd0;
  logic [3:0]  glitch = 4'd0;
  int          total = 0, bad = 0;

  keypad_scan_ctrl #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset(reset), .rows_in(rows_in), .cols_out(cols_out),
    .address(address), .chipselect(chipselect), .read(read), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven
  always_comb begin
    logic [3:0] low;
    low = glitch;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && !cols_out[c]) low[r] = 1'b1;
    rows_in = ~low;
  end

  // Reference model: scanning is a phase 0..FR-1 within the frame
  bit          m_scan = 0, m_en = 0, m_irq_en = 0, m_valid = 0, m_over = 0, m_pressed = 0;
  int          m_ph = 0, m_run = 0;
  logic [11:0] m_frame = 0, m_prev = 0, m_snap = 0;
  logic [3:0]  m_code = 0, m_s1 = 4'hF, m_s2 = 4'hF;
  logic [2:0]  m_cols = 3'b111;

  always @(posedge clk) begin
    logic [3:0] seen;
    bit rd, nk;
    if (reset) begin
      m_scan = 0; m_en = 0; m_irq_en = 0; m_valid = 0; m_over = 0; m_pressed = 0;
      m_ph = 0; m_run = 0; m_frame = 0; m_prev = 0; m_snap = 0; m_code = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_cols = 3'b111;
    end else begin
      rd = chipselect && read && address == 2'd0;
      nk = 0;
      seen = glitch;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 3; c++)
          if (keys[r*3+c] && !m_cols[c]) seen[r] = 1'b1;
      seen = ~seen;
      if (!m_en) begin
        m_scan = 0; m_run = 0;
      end else if (!m_scan) begin
        m_scan = 1; m_ph = 0;
      end else begin
        if (m_ph < 3*S && m_ph % S == S-1)
          for (int r = 0; r < 4; r++) m_frame[r*3 + m_ph/S] = ~m_s2[r];
        if (m_ph == 3*S) begin
          m_run  = (m_frame == m_prev) ? m_run + 1 : 1;
          m_prev = m_frame;
          if (m_run == DB) begin
            m_snap = m_frame;
            if ($countones(m_frame) == 1 && !m_pressed) begin
              nk = 1; m_pressed = 1;
              for (int i = 0; i < 12; i++) if (m_frame[i]) m_code = 4'(i);
            end else if (m_frame == 0) m_pressed = 0;
          end
        end
        m_ph = (m_ph + 1) % FR;
      end
      m_over  = rd ? 1'b0 : (m_over | (nk & m_valid));
      m_valid = nk | (m_valid & !rd);
      if (chipselect && !write_n && address == 2'd1) begin
        m_en = writedata[0]; m_irq_en = writedata[1];
      end
      m_s2 = m_s1; m_s1 = seen;
      m_cols = (m_scan && m_ph < 3*S) ? ~(3'b001 << (m_ph / S)) : 3'b111;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {21'd0, m_pressed, m_over, m_valid, 4'd0, m_code};
      2'd1:    return {30'd0, m_irq_en, m_en};
      2'd2:    return {20'd0, m_snap};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      chk("cols_model", {29'd0, cols_out}, {29'd0, m_cols});
      chk("irq_model", {31'd0, irq}, {31'd0, m_valid & m_irq_en});
    end
  endtask

  task automatic peek(input string tag, input logic [1:0] a, output logic [31:0] v);
    address = a; #1;
    chk(tag, readdata, exp_rd(a));
    v = readdata;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, output logic [31:0] v);
    address = a; chipselect = 1'b1; read = 1'b1; #1;
    chk(tag, readdata, exp_rd(a));
    v = readdata;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wait_cols(input string tag, input logic [2:0] v);
    int n = 0;
    while (cols_out !== v && n < 40) begin cyc(1); n++; end
    chk(tag, {29'd0, cols_out}, {29'd0, v});
  endtask

  task automatic wait_scan_start(input string tag);
    int n = 0;
    while (cols_out === 3'b111 && n < 40) begin cyc(1); n++; end
    chk(tag, {29'd0, cols_out}, 32'd6);
  endtask

  initial begin
    logic [31:0] v;
    logic [2:0]  tbl;
    int          code;

    cyc(3);
    reset = 1'b0;
    cyc(2);
    chk("rst_cols", {29'd0, cols_out}, 32'd7);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    peek("rst_stat", 2'd0, v); chk("rst_stat_c", v, 32'd0);
    peek("rst_ctrl", 2'd1, v); chk("rst_ctrl_c", v, 32'd0);
    peek("rst_snap", 2'd2, v); chk("rst_snap_c", v, 32'd0);
    cyc(5);
    chk("idle_cols", {29'd0, cols_out}, 32'd7);

    // Column sequence over one frame and into the next
    wr(2'd1, 32'd1);
    wait_scan_start("scan_start");
    for (int i = 0; i < FR + 4; i++) begin
      tbl = (i % FR < S) ? 3'b110 : (i % FR < 2*S) ? 3'b101 : (i % FR < 3*S) ? 3'b011 : 3'b111;
      chk("col_seq", {29'd0, cols_out}, {29'd0, tbl});
      cyc(1);
    end

    // Steady press of row 2 col 1, reported once
    wr(2'd1, 32'd3);
    keys = 12'd1 << 7;
    cyc(3*FR + 4);
    chk("key7_irq", {31'd0, irq}, 32'd1);
    rd("key7_rd", 2'd0, v); chk("key7_c", v, 32'h507);
    cyc(10*FR);
    peek("key7_hold", 2'd0, v); chk("key7_hold_c", v, 32'h407);
    peek("key7_snap", 2'd2, v); chk("key7_snap_c", v, 32'h080);

    // Row 0 bounce aligned to a frame start, then col 0 held
    keys = 12'd0;
    cyc(3*FR + 4);
    wait_cols("bounce_align", 3'b110);
    for (int i = 0; i < 3*FR; i++) begin
      if (i % 5 == 0) glitch[0] = ~glitch[0];
      cyc(1);
    end
    chk("bounce_noirq", {31'd0, irq}, 32'd0);
    glitch = 4'd0;
    keys = 12'd1;
    cyc(2*FR + 4);
    chk("key0_irq", {31'd0, irq}, 32'd1);
    rd("key0_rd", 2'd0, v); chk("key0_c", v, 32'h500);

    // Same key twice without a read
    keys = 12'd0;   cyc(3*FR + 4);
    keys = 12'd1 << 4; cyc(3*FR + 4);
    keys = 12'd0;   cyc(3*FR + 4);
    keys = 12'd1 << 4; cyc(3*FR + 4);
    rd("ovr_rd", 2'd0, v); chk("ovr_c", v, 32'h704);
    cyc(1);
    peek("ovr_clr", 2'd0, v); chk("ovr_clr_c", v, 32'h404);

    // Two keys on one row, then one of them alone
    keys = 12'd0; cyc(3*FR + 4);
    keys = (12'd1 << 3) | (12'd1 << 5); cyc(3*FR + 4);
    peek("multi_snap", 2'd2, v); chk("multi_snap_c", v, 32'h028);
    peek("multi_stat", 2'd0, v); chk("multi_stat_c", v, 32'h004);
    keys = 12'd1 << 5; cyc(3*FR + 4);
    rd("key5_rd", 2'd0, v); chk("key5_c", v, 32'h505);

    // Random keys pressed at random frame phases
    for (int k = 0; k < 4; k++) begin
      keys = 12'd0; cyc(3*FR + 4);
      rd("rnd_pre", 2'd0, v);
      code = int'($urandom_range(0, 11));
      cyc(int'($urandom_range(0, FR - 1)));
      keys = 12'd1 << code;
      cyc(3*FR + 4);
      rd("rnd_rd", 2'd0, v); chk("rnd_c", v, 32'h500 | 32'(code));
    end

    // Disable during col 1, then re-enable
    wait_cols("dis_align", 3'b101);
    wr(2'd1, 32'd2);
    cyc(2);
    chk("dis_cols", {29'd0, cols_out}, 32'd7);
    cyc(20);
    chk("dis_idle", {29'd0, cols_out}, 32'd7);
    wr(2'd1, 32'd3);
    wait_scan_start("reen_start");

    // Reset landing in the EVAL cycle with a pending key
    keys = 12'd1 << 9; cyc(3*FR + 4);
    wait_cols("eval_a", 3'b011);
    wait_cols("eval_b", 3'b111);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst2_cols", {29'd0, cols_out}, 32'd7);
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    peek("rst2_stat", 2'd0, v); chk("rst2_stat_c", v, 32'd0);
    peek("rst2_ctrl", 2'd1, v); chk("rst2_ctrl_c", v, 32'd0);
    peek("rst2_snap", 2'd2, v); chk("rst2_snap_c", v, 32'd0);
    reset = 1'b0;
    cyc(FR);
    chk("rst2_idle", {29'd0, cols_out}, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Autonomous scanner for the 3-column x 4-row telephone keypad.
- Replaces software bit-banging of the column PIO: drives one column low at a time, samples the rows, debounces whole scan frames and encodes a single keypress.
- Presents the key to the Nios II over a small Avalon-MM slave with an interrupt.
- Sits between the keypad pins and the system interconnect in top_level.

Parameters:
- SETTLE_CYCLES, 500, clk cycles each column is driven before rows are sampled (>= 3).
- DEBOUNCE_SCANS, 4, consecutive identical frames required before a snapshot is accepted (>= 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- rows_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- cols_out  out  3  keypad column drive, active-low.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- read  in  1  Avalon read strobe; qualified by chipselect.
- write_n  in  1  Avalon write strobe, active-low; qualified by chipselect.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational from address, zero-latency.
- irq  out  1  level interrupt = valid & irq_en.

Behaviour:
- Clock and reset: single clock. reset is synchronous, active-high, and wins over every other event in the same cycle.
- Reset values:
  - cols_out = 3'b111; all state cleared.
  - enable = 0, irq_en = 0, valid = 0, overrun = 0, pressed = 0, code = 0.
  - Snapshots = 0, stable count = 0, FSM = IDLE, irq = 0.
- Row synchroniser: rows_in passes through a 2-flop synchroniser. The synchroniser resets to 4'b1111.
- FSM:
  - IDLE: cols_out = 3'b111. Go to DRIVE with col = 0 when enable = 1.
  - DRIVE: cols_out has only bit col low. Settle counter runs 0..SETTLE_CYCLES-1.
    - On the last count, capture the inverted synchronised rows into frame bits [row*3+col].
    - Then col+1 → DRIVE, or after col 2 → EVAL.
  - EVAL (1 cycle): cols_out = 3'b111; run debounce (below). Then col = 0 → DRIVE.
  - enable cleared in any state: next cycle → IDLE, cols_out = 3'b111, partial frame discarded, stable count = 0. valid, code and overrun are kept.
- Frame timing: one frame = 3*SETTLE_CYCLES + 1 cycles.
- Debounce in EVAL:
  - If frame == prev_frame, stable count saturates at DEBOUNCE_SCANS. Otherwise stable count = 1. Then prev_frame <= frame.
  - When the count first reaches DEBOUNCE_SCANS, the debounced snapshot <= frame, and:
    - Exactly one bit set and pressed = 0: code <= index (row*3+col, 0..11), pressed <= 1, valid <= 1. If valid was already 1, overrun <= 1.
    - Zero bits set: pressed <= 0. Release re-arms, so the same key may be reported again.
    - Two or more bits set (ghosting/multi-press): no new key reported; pressed unchanged.
  - A held key is reported exactly once.
- Register map:
  - addr 0, read: bit 8 valid, bit 9 overrun, bit 10 pressed, bits [3:0] code, others 0.
    - A read of addr 0 clears valid and overrun next cycle.
    - If a new key latches in the same cycle as the read, valid stays 1, overrun is cleared, and the new code is stored.
  - addr 1, R/W: bit 0 enable, bit 1 irq_en. Other bits write-ignored and read 0.
  - addr 2, read: bits [11:0] debounced snapshot.
  - addr 3: reads 0.
  - Writes to read-only addresses are ignored.

Test Plan:
Benches use SETTLE_CYCLES = 4 and DEBOUNCE_SCANS = 2 (frame = 13 cycles).
- Reset then idle → cols_out = 3'b111, readdata at addr 0 = 0, irq = 0. After a write of 1 to addr 1, cols_out steps 110 → 101 → 011, 4 cycles each, then 111 for 1 cycle, then repeats.
- Press key at row 2, col 1, held steady → after the 2nd identical frame EVAL: addr 0 reads 0x507 (pressed, valid, code 7); irq = 1 when irq_en = 1. Holding for 10 more frames produces no further report.
- Bounce: toggle row 0 every 5 cycles for 3 frames, then hold col 0 → single report code 0, only after 2 stable frames. No report occurs during bouncing.
- Press code 4, release, press code 4 again without reading → code 4, valid = 1, overrun = 1. Reading addr 0 → next cycle valid = 0, overrun = 0.
- Hold keys code 3 and code 5 together → addr 2 reads 0x028, no valid. Release to a single key code 5 → code 5 reported.
- Clear enable mid-DRIVE of col 1 → next cycle cols_out = 111 and the FSM stays in IDLE. Re-enable → scan restarts at col 0. Assert reset during EVAL → all registers return to reset values the following cycle.
